tilemap_writer: RTL and testbench

Buffers tilemap update requests from a host-side producer and drains them into the 1024×8 tilemap VRAM only during horizontal blanking, so the tile renderer keeps exclusive use of the VRAM port during active pixels. Sits directly upstream of the tilemap renderer on the VRAM write side and replaces its one-shot init sweep. Supports single-byte writes and run-length fills. The top-level mux gives the VRAM port to this block whenever its `VRAM_WE` is high.

---
 rtl/tilemap_writer.sv | 220 ++++++++++++++++++++++
 tb/tb_tilemap_writer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilemap_writer.sv
// ---------------------------------------------------------------------------
// tilemap_writer
//
// Buffers tilemap update requests from the host side and drains them into
// the 1024x8 tilemap VRAM only while HCOUNT is inside the horizontal-blank
// write window. The tile renderer keeps the VRAM port for itself during
// active pixels. The top-level mux hands the port to this block whenever
// VRAM_WE is high.
//
// Request handshake (valid/ready):
//   A request transfers on a rising CLK_VGA edge where REQ_VALID and
//   REQ_READY are both high. The producer holds REQ_* stable while
//   REQ_VALID is high and REQ_READY is low. REQ_READY depends only on the
//   FIFO occupancy and RESET, never on REQ_VALID. A full FIFO keeps
//   REQ_READY low even in a cycle where an entry is popped.
//
// Ports:
//   CLK_VGA    in   pixel clock; the only clock
//   RESET      in   synchronous, active-high
//   HCOUNT     in   horizontal counter, 0..799
//   REQ_VALID  in   request present
//   REQ_READY  out  request can be accepted
//   REQ_FILL   in   0 = single write, 1 = run-length fill
//   REQ_ADDR   in   tilemap address {row[4:0], col[4:0]}
//   REQ_DATA   in   tile byte
//   REQ_LEN    in   fill length minus one (ignored for single writes)
//   VRAM_ADDR  out  registered write address
//   VRAM_DIN   out  registered write data
//   VRAM_WE    out  registered write strobe / port grant
//   BUSY       out  FIFO non-empty or a fill is in progress
// ---------------------------------------------------------------------------
module tilemap_writer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int BLANK_START = 640,
    parameter int BLANK_END   = 797
) (
    input  logic       CLK_VGA,
    input  logic       RESET,
    input  logic [9:0] HCOUNT,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_FILL,
    input  logic [9:0] REQ_ADDR,
    input  logic [7:0] REQ_DATA,
    input  logic [9:0] REQ_LEN,
    output logic [9:0] VRAM_ADDR,
    output logic [7:0] VRAM_DIN,
    output logic       VRAM_WE,
    output logic       BUSY
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [9:0]  WIN_LO   = 10'(BLANK_START);
    localparam logic [9:0]  WIN_HI   = 10'(BLANK_END);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } drain_state_t;

    // -----------------------------------------------------------------------
    // Request FIFO: entry layout {fill, addr[9:0], data[7:0], len[9:0]}
    // -----------------------------------------------------------------------
    logic [28:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_n;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;

    logic [28:0]   head_entry;
    logic          head_fill;
    logic [9:0]    head_addr;
    logic [7:0]    head_data;
    logic [9:0]    head_len;

    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign REQ_READY  = !fifo_full && !RESET;
    assign push       = REQ_VALID && REQ_READY;

    assign head_entry = fifo_mem[rd_ptr];
    assign head_fill  = head_entry[28];
    assign head_addr  = head_entry[27:18];
    assign head_data  = head_entry[17:10];
    assign head_len   = head_entry[9:0];

    // Storage has no reset: only entries below the occupancy count are read.
    always_ff @(posedge CLK_VGA) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {REQ_FILL, REQ_ADDR, REQ_DATA, REQ_LEN};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_n;
        end
    end

    always_comb begin
        count_n = count + (AW+1)'(push) - (AW+1)'(pop);
    end

    // -----------------------------------------------------------------------
    // Write window: evaluated on the live HCOUNT, so a write decided in the
    // cycle showing HCOUNT=h appears on VRAM_WE during HCOUNT=h+1.
    // -----------------------------------------------------------------------
    logic win;
    assign win = (HCOUNT >= WIN_LO) && (HCOUNT <= WIN_HI);

    // -----------------------------------------------------------------------
    // Drain FSM
    // -----------------------------------------------------------------------
    drain_state_t state;
    drain_state_t state_n;
    logic [9:0]   cur_addr;
    logic [9:0]   cur_addr_n;
    logic [9:0]   remain;
    logic [9:0]   remain_n;
    logic         issue;
    logic [9:0]   wr_addr;
    logic [7:0]   wr_din;

    always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
            state    <= ST_IDLE;
            cur_addr <= '0;
            remain   <= '0;
        end else begin
            state    <= state_n;
            cur_addr <= cur_addr_n;
            remain   <= remain_n;
        end
    end

    always_comb begin
        state_n    = state;
        cur_addr_n = cur_addr;
        remain_n   = remain;
        pop        = 1'b0;
        issue      = 1'b0;
        wr_addr    = cur_addr;
        wr_din     = head_data;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty && win) begin
                    issue   = 1'b1;
                    wr_addr = head_addr;
                    if (!head_fill || (head_len == 10'd0)) begin
                        pop = 1'b1;
                    end else begin
                        // The head stays in the FIFO for the whole fill so its
                        // data byte is read straight from storage each write.
                        cur_addr_n = head_addr + 10'd1;
                        remain_n   = head_len - 10'd1;
                        state_n    = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                // Outside the window everything holds and the run resumes
                // in the next line's blanking interval.
                if (win) begin
                    issue      = 1'b1;
                    wr_addr    = cur_addr;
                    cur_addr_n = cur_addr + 10'd1;
                    if (remain == 10'd0) begin
                        pop     = 1'b1;
                        state_n = ST_IDLE;
                    end else begin
                        remain_n = remain - 10'd1;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered VRAM port and status. Address and data hold their last
    // values when no write is issued, so only VRAM_WE toggles.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
            VRAM_WE   <= 1'b0;
            VRAM_ADDR <= '0;
            VRAM_DIN  <= '0;
            BUSY      <= 1'b0;
        end else begin
            VRAM_WE <= issue;
            if (issue) begin
                VRAM_ADDR <= wr_addr;
                VRAM_DIN  <= wr_din;
            end
            BUSY <= (count_n != '0) || (state_n == ST_FILL);
        end
    end

endmodule

// File: tb/tb_tilemap_writer.sv
// ---------------------------------------------------------------------------
// tb_tilemap_writer
//
// Bench for tilemap_writer. The reference keeps a flat queue of every VRAM
// write still owed (each accepted request expanded into its individual
// address/data pairs) plus a per-request queue of outstanding write counts.
// One owed write retires on each edge whose pre-edge HCOUNT lies in the
// window; the whole output bundle is compared every cycle.
// ---------------------------------------------------------------------------
module tb_tilemap_writer;

    localparam int DEPTH = 8;
    localparam int BS    = 640;
    localparam int BE    = 797;

    // ------------------------------------------------------------------
    // Clock / reset / line timing
    // ------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hcount = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        hcount <= (hcount == 10'd799) ? 10'd0 : hcount + 10'd1;
    end

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic       req_valid = 1'b0;
    logic       req_fill  = 1'b0;
    logic [9:0] req_addr  = '0;
    logic [7:0] req_data  = '0;
    logic [9:0] req_len   = '0;
    logic       req_ready;
    logic [9:0] vram_addr;
    logic [7:0] vram_din;
    logic       vram_we;
    logic       busy;

    tilemap_writer #(
        .FIFO_DEPTH (DEPTH),
        .BLANK_START(BS),
        .BLANK_END  (BE)
    ) dut (
        .CLK_VGA  (clk),
        .RESET    (rst),
        .HCOUNT   (hcount),
        .REQ_VALID(req_valid),
        .REQ_READY(req_ready),
        .REQ_FILL (req_fill),
        .REQ_ADDR (req_addr),
        .REQ_DATA (req_data),
        .REQ_LEN  (req_len),
        .VRAM_ADDR(vram_addr),
        .VRAM_DIN (vram_din),
        .VRAM_WE  (vram_we),
        .BUSY     (busy)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;

    logic [17:0] exp_q[$];   // owed writes {addr, din} in order
    int          req_q[$];   // writes still owed per accepted request
    logic        m_we   = 1'b0;
    logic [9:0]  m_addr = '0;
    logic [7:0]  m_din  = '0;
    logic        m_rdy;
    logic        m_busy;
    logic [17:0] w;
    logic [9:0]  a;
    int          n;

    // Observation of writes for the table checks
    int          obs_cnt      = 0;
    int          obs_first_hc = 0;
    logic [9:0]  obs_last_addr = '0;
    logic [7:0]  obs_last_din  = '0;

    always @(negedge clk) begin
        cyc++;
        m_rdy  = !rst && (req_q.size() < DEPTH);
        m_busy = (req_q.size() != 0);

        n_cmp++;
        if ({vram_we, vram_addr, vram_din, req_ready, busy} !==
            {m_we, m_addr, m_din, m_rdy, m_busy}) begin
            n_fail++;
            $display("FAIL cycle_check hc=%0d got we=%b addr=%h din=%h rdy=%b busy=%b expected we=%b addr=%h din=%h rdy=%b busy=%b",
                     hcount, vram_we, vram_addr, vram_din, req_ready, busy,
                     m_we, m_addr, m_din, m_rdy, m_busy);
        end

        if (vram_we === 1'b1) begin
            n_cmp++;
            if (hcount < 10'd641 || hcount > 10'd798) begin
                n_fail++;
                $display("FAIL window_guard VRAM_WE seen at hc=%0d expected within 641..798", hcount);
            end
            if (obs_cnt == 0) obs_first_hc = int'(hcount);
            obs_cnt++;
            obs_last_addr = vram_addr;
            obs_last_din  = vram_din;
        end

        // Predict what the coming edge does.
        if (rst) begin
            exp_q.delete();
            req_q.delete();
            m_we   = 1'b0;
            m_addr = '0;
            m_din  = '0;
        end else begin
            m_we = 1'b0;
            if (int'(hcount) >= BS && int'(hcount) <= BE && exp_q.size() != 0) begin
                w      = exp_q.pop_front();
                m_addr = w[17:8];
                m_din  = w[7:0];
                m_we   = 1'b1;
                req_q[0] = req_q[0] - 1;
                if (req_q[0] == 0) void'(req_q.pop_front());
            end
            if (req_valid && m_rdy) begin
                n = req_fill ? int'(req_len) + 1 : 1;
                a = req_addr;
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back({a, req_data});
                    a = a + 10'd1;
                end
                req_q.push_back(n);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (called from posedge+2 context)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic timeout_fail(input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s timed out", what);
    endtask

    task automatic wait_hc(input int v);
        for (int k = 0; k < 2000; k++) begin
            if (int'(hcount) == v) return;
            step();
        end
        timeout_fail("wait_hc");
    endtask

    task automatic push_req(input logic f, input logic [9:0] ad, input logic [7:0] d,
                            input logic [9:0] l, output int acc_hc);
        acc_hc    = -1;
        req_fill  = f;
        req_addr  = ad;
        req_data  = d;
        req_len   = l;
        req_valid = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                acc_hc = int'(hcount);
                step();
                req_valid = 1'b0;
                return;
            end
            step();
        end
        req_valid = 1'b0;
        timeout_fail("push_req");
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                step();
                return;
            end
        end
        step();
        timeout_fail("wait_idle");
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vectors
    // ------------------------------------------------------------------
    typedef struct {
        int         push_hc;
        logic       fill;
        logic [9:0] addr;
        logic [7:0] data;
        logic [9:0] len;
        int         exp_cnt;
        int         exp_first_hc;
        logic [9:0] exp_last_addr;
        logic [7:0] exp_last_din;
    } vec_t;

    vec_t vecs[7];
    int   acc;
    int   acc_hcs[9];

    initial begin
        vecs[0] = '{100, 1'b0, 10'h021, 8'h85, 10'd0,    1,    641, 10'h021, 8'h85};
        vecs[1] = '{100, 1'b1, 10'h3FE, 8'h11, 10'd3,    4,    641, 10'h001, 8'h11};
        vecs[2] = '{640, 1'b1, 10'h000, 8'h4F, 10'd1023, 1024, 642, 10'h3FF, 8'h4F};
        vecs[3] = '{300, 1'b1, 10'h155, 8'hAA, 10'd0,    1,    641, 10'h155, 8'hAA};
        vecs[4] = '{797, 1'b0, 10'h3FF, 8'h7E, 10'd5,    1,    641, 10'h3FF, 8'h7E};
        vecs[5] = '{500, 1'b1, 10'h100, 8'hC3, 10'd157,  158,  641, 10'h19D, 8'hC3};
        vecs[6] = '{796, 1'b1, 10'h200, 8'h5A, 10'd2,    3,    798, 10'h202, 8'h5A};

        // Reset
        rst = 1'b1;
        repeat (4) step();
        rst = 1'b0;
        step();

        // Table-driven single requests
        for (int i = 0; i < 7; i++) begin
            wait_hc(vecs[i].push_hc);
            obs_cnt = 0;
            push_req(vecs[i].fill, vecs[i].addr, vecs[i].data, vecs[i].len, acc);
            wait_idle(8000);
            check_int($sformatf("vec%0d_count", i), obs_cnt, vecs[i].exp_cnt);
            check_int($sformatf("vec%0d_first_hc", i), obs_first_hc, vecs[i].exp_first_hc);
            check_int($sformatf("vec%0d_last_addr", i), int'(obs_last_addr), int'(vecs[i].exp_last_addr));
            check_int($sformatf("vec%0d_last_din", i), int'(obs_last_din), int'(vecs[i].exp_last_din));
        end

        // Backpressure: nine back-to-back writes from HCOUNT=0
        wait_hc(0);
        for (int i = 0; i < 9; i++) begin
            push_req(1'b0, 10'(10'h040 + i), 8'(8'h10 + i), 10'd0, acc_hcs[i]);
        end
        check_int("bp_8th_accept_hc", acc_hcs[7], 7);
        check_int("bp_9th_accept_hc", acc_hcs[8], 641);
        wait_idle(2000);

        // Reset mid-fill
        wait_hc(600);
        push_req(1'b1, 10'h0A0, 8'h33, 10'd1023, acc);
        wait_hc(700);
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs_cnt = 0;
        wait_hc(0);
        wait_hc(799);
        check_int("rst_no_writes", obs_cnt, 0);
        check_int("rst_busy", int'(busy), 0);

        // Randomized traffic keeping the FIFO mostly non-empty
        begin
            int stop_cyc;
            stop_cyc = cyc + 16000;
            while (cyc < stop_cyc) begin
                push_req(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                         8'($urandom_range(0, 255)), 10'($urandom_range(0, 40)), acc);
                repeat ($urandom_range(0, 2)) step();
            end
        end
        wait_idle(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
